// File: rtl/single_port_ram_no_change.sv
// Single-port synchronous block RAM, NO_CHANGE write mode, optional output register.
// Define SPRAM_INIT_EN to preload the array with zeros.
module single_port_ram_no_change #(
  parameter int unsigned RAM_WIDTH       = 18,
  parameter int unsigned RAM_DEPTH       = 1024,
  parameter string       RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter string       INIT_FILE       = "",
  // clogb2(RAM_DEPTH-1) equals the bit length of RAM_DEPTH-1, i.e. $clog2(RAM_DEPTH)
  localparam int unsigned AW = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 rsta,
  input  logic                 ena,
  input  logic                 wea,
  input  logic                 regcea,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic [AW-1:0]        addra,
  output logic [RAM_WIDTH-1:0] douta
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;
  logic                 addr_ok_c;
  logic                 unused_init;

  // Range check only exists when the address space is wider than the array
  generate
    if (RAM_DEPTH < (32'd1 << AW)) begin : g_range
      assign addr_ok_c = (32'(addra) < RAM_DEPTH);
    end else begin : g_full
      assign addr_ok_c = 1'b1;
    end
  endgenerate

  assign unused_init = (INIT_FILE == "");

`ifdef SPRAM_INIT_EN
  initial begin
    for (int unsigned i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
  end
`endif

  // Array write; the output reset never touches the contents
  always_ff @(posedge clka) begin
    if (ena && wea && addr_ok_c) begin
      mem[addra] <= dina;
    end
  end

  // Read latch: only loads on enabled non-write cycles (NO_CHANGE)
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      ram_data <= '0;
    end else if (ena && !wea) begin
      ram_data <= addr_ok_c ? mem[addra] : '0;
    end
  end

  generate
    if (RAM_PERFORMANCE == "HIGH_PERFORMANCE") begin : g_hp
      logic [RAM_WIDTH-1:0] douta_reg;

      always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
          douta_reg <= '0;
        end else if (regcea) begin
          douta_reg <= ram_data;
        end
      end

      assign douta = douta_reg;
    end else begin : g_ll
      logic unused_regcea;
      assign unused_regcea = regcea;
      assign douta         = ram_data;
    end
  endgenerate

endmodule

// File: tb/tb_single_port_ram_no_change.sv
// Randomized bench for single_port_ram_no_change: HIGH_PERFORMANCE and LOW_LATENCY
// instances share stimulus and are checked against a word-level model every cycle.
module tb_single_port_ram_no_change;

  localparam int unsigned W  = 18;
  localparam int unsigned D  = 1024;
  localparam int unsigned AW = 10;

  logic          clka = 1'b0;
  logic          rsta, ena, wea, regcea;
  logic [W-1:0]  dina;
  logic [AW-1:0] addra;
  logic [W-1:0]  douta_hp, douta_ll;

  always #5 clka = ~clka;

  single_port_ram_no_change #(
    .RAM_WIDTH(W), .RAM_DEPTH(D), .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .INIT_FILE("")
  ) dut_hp (
    .clka(clka), .rsta(rsta), .ena(ena), .wea(wea), .regcea(regcea),
    .dina(dina), .addra(addra), .douta(douta_hp)
  );

  single_port_ram_no_change #(
    .RAM_WIDTH(W), .RAM_DEPTH(D), .RAM_PERFORMANCE("LOW_LATENCY"), .INIT_FILE("")
  ) dut_ll (
    .clka(clka), .rsta(rsta), .ena(ena), .wea(wea), .regcea(regcea),
    .dina(dina), .addra(addra), .douta(douta_ll)
  );

  int errors = 0;
  int checks = 0;
  bit run    = 1'b0;

  // Model: word array with written flags, the last read word, and the registered output
  logic [W-1:0] m_mem [D];
  bit           m_known [D];
  logic [W-1:0] m_rd, m_reg;
  bit           m_rd_k, m_reg_k;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = '0; m_reg = '0; m_rd_k = 1'b1; m_reg_k = 1'b1;
  endtask

  task automatic model_edge();
    if (rsta) begin
      model_reset();
    end else begin
      if (regcea) begin
        m_reg = m_rd; m_reg_k = m_rd_k;
      end
      if (ena && !wea) begin
        m_rd = m_mem[addra]; m_rd_k = m_known[addra];
      end
    end
    if (ena && wea) begin
      m_mem[addra] = dina; m_known[addra] = 1'b1;
    end
  endtask

  task automatic step(input logic e, input logic w, input logic r,
                      input logic [AW-1:0] a, input logic [W-1:0] d);
    ena = e; wea = w; regcea = r; addra = a; dina = d;
    @(posedge clka);
    model_edge();
    #1;
  endtask

  // Compare both outputs against the model once per cycle
  always @(negedge clka) begin
    if (run) begin
      if (m_reg_k) check("hp_douta", douta_hp, m_reg);
      if (m_rd_k)  check("ll_douta", douta_ll, m_rd);
    end
  end

  initial begin
    rsta = 1'b1; ena = 1'b0; wea = 1'b0; regcea = 1'b0; addra = '0; dina = '0;
    for (int i = 0; i < D; i++) begin
      m_mem[i] = '0; m_known[i] = 1'b0;
    end
`ifdef SPRAM_INIT_EN
    for (int i = 0; i < D; i++) m_known[i] = 1'b1;
`endif
    model_reset();
    #1;
    check("reset_hp", douta_hp, 18'h00000);
    check("reset_ll", douta_ll, 18'h00000);
    run = 1'b1;
    step(1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    rsta = 1'b0;

`ifdef SPRAM_INIT_EN
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, AW'(i), '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    check("init_zero_hp", douta_hp, 18'h00000);
`endif

    // Full write sweep then sequential read-back
    for (int i = 0; i < D; i++) step(1'b1, 1'b1, 1'b1, AW'(i), W'($urandom));
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b1, AW'(i), '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);

    // Async reset leaves the array alone; writes during reset still land
    step(1'b1, 1'b1, 1'b1, 10'd5, 18'h2A5A3);
    step(1'b1, 1'b0, 1'b1, 10'd5, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    check("pre_reset_hp", douta_hp, 18'h2A5A3);
    check("pre_reset_ll", douta_ll, 18'h2A5A3);
    rsta = 1'b1;
    model_reset();
    #1;
    check("async_reset_hp", douta_hp, 18'h00000);
    check("async_reset_ll", douta_ll, 18'h00000);
    step(1'b1, 1'b1, 1'b1, 10'd6, 18'h15555);
    rsta = 1'b0;
    step(1'b1, 1'b0, 1'b1, 10'd5, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    check("post_reset_hp", douta_hp, 18'h2A5A3);
    step(1'b1, 1'b0, 1'b1, 10'd6, '0);
    check("write_in_reset_ll", douta_ll, 18'h15555);

    // NO_CHANGE: writes do not disturb the output
    step(1'b1, 1'b1, 1'b1, 10'd3, 18'h00011);
    step(1'b1, 1'b0, 1'b1, 10'd3, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    check("nc_read_hp", douta_hp, 18'h00011);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 10'd7, 18'h3FFFF);
      check("nc_hold_hp", douta_hp, 18'h00011);
      check("nc_hold_ll", douta_ll, 18'h00011);
    end
    step(1'b1, 1'b0, 1'b1, 10'd7, '0);
    check("nc_after_ll", douta_ll, 18'h3FFFF);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    check("nc_after_hp", douta_hp, 18'h3FFFF);

    // ena gates writes
    step(1'b1, 1'b1, 1'b1, 10'd9, 18'h00999);
    step(1'b0, 1'b1, 1'b1, 10'd9, 18'h12345);
    step(1'b1, 1'b0, 1'b1, 10'd9, '0);
    check("ena_gate_ll", douta_ll, 18'h00999);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    check("ena_gate_hp", douta_hp, 18'h00999);

    // regcea holds the output register
    step(1'b1, 1'b1, 1'b1, 10'd10, 18'h0BEEF);
    step(1'b1, 1'b0, 1'b0, 10'd10, '0);
    check("regcea_ll", douta_ll, 18'h0BEEF);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    check("regcea_hold_hp", douta_hp, 18'h00999);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    check("regcea_load_hp", douta_hp, 18'h0BEEF);

    // Low-latency path ignores regcea
    step(1'b1, 1'b1, 1'b0, 10'd1023, 18'h0ABCD);
    step(1'b1, 1'b0, 1'b0, 10'd1023, '0);
    check("ll_1023", douta_ll, 18'h0ABCD);

    // Random traffic on a small address window, with occasional mid-cycle resets
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (!rsta && r < 2) begin
        rsta = 1'b1;
        model_reset();
      end else if (rsta && r < 50) begin
        rsta = 1'b0;
      end
      step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
           AW'($urandom_range(0, 31)), W'($urandom));
    end
    rsta = 1'b0;
    step(1'b0, 1'b0, 1'b1, '0, '0);
    run = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
